// File: rtl/sramlike_arb_3x1.sv
`default_nettype none
// ============================================================================
// Module   : sramlike_arb_3x1
// Brief    : Three-to-one sram-like port arbiter in front of the AXI bridge.
//            Round-robin (or fixed s2 > s1 > s0) grant, one outstanding
//            transaction, sticky flag for stray m_data_ok pulses.
// Revision : 1.0 - initial release
// ============================================================================
module sramlike_arb_3x1 #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter bit RR_EN  = 1'b1
) (
   input  logic              aclk,
   input  logic              aresetn,
   input  logic              s0_req,
   input  logic              s0_wr,
   input  logic [1:0]        s0_size,
   input  logic [ADDR_W-1:0] s0_addr,
   input  logic [DATA_W-1:0] s0_wdata,
   output logic [DATA_W-1:0] s0_rdata,
   output logic              s0_addr_ok,
   output logic              s0_data_ok,
   input  logic              s1_req,
   input  logic              s1_wr,
   input  logic [1:0]        s1_size,
   input  logic [ADDR_W-1:0] s1_addr,
   input  logic [DATA_W-1:0] s1_wdata,
   output logic [DATA_W-1:0] s1_rdata,
   output logic              s1_addr_ok,
   output logic              s1_data_ok,
   input  logic              s2_req,
   input  logic              s2_wr,
   input  logic [1:0]        s2_size,
   input  logic [ADDR_W-1:0] s2_addr,
   input  logic [DATA_W-1:0] s2_wdata,
   output logic [DATA_W-1:0] s2_rdata,
   output logic              s2_addr_ok,
   output logic              s2_data_ok,
   output logic              m_req,
   output logic              m_wr,
   output logic [1:0]        m_size,
   output logic [ADDR_W-1:0] m_addr,
   output logic [DATA_W-1:0] m_wdata,
   input  logic [DATA_W-1:0] m_rdata,
   input  logic              m_addr_ok,
   input  logic              m_data_ok,
   output logic              busy,
   output logic              err_stray
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] ADDR = 2'd1;
   localparam logic [1:0] DATA = 2'd2;

   logic [1:0] state;
   logic [1:0] grant;
   logic [1:0] last;
   logic [1:0] winner;
   logic [2:0] req_v;
   logic       cur_req;
   logic [2:0] aok_v;
   logic [2:0] dok_v;
   logic       stray;

   assign req_v = {s2_req, s1_req, s0_req};

   // Winner selection: rotating priority starting after the last served port,
   // or static priority when rotation is disabled.
   generate
      if (RR_EN) begin : g_rr
         always_comb begin
            winner = 2'd0;
            case (last)
               2'd0:    winner = req_v[1] ? 2'd1 : (req_v[2] ? 2'd2 : 2'd0);
               2'd1:    winner = req_v[2] ? 2'd2 : (req_v[0] ? 2'd0 : 2'd1);
               default: winner = req_v[0] ? 2'd0 : (req_v[1] ? 2'd1 : 2'd2);
            endcase
         end
      end else begin : g_fixed
         always_comb begin
            winner = req_v[2] ? 2'd2 : (req_v[1] ? 2'd1 : 2'd0);
         end
      end
   endgenerate

   // Forward the granted requester's command fields to the master port.
   always_comb begin
      cur_req = s0_req;
      m_wr    = s0_wr;
      m_size  = s0_size;
      m_addr  = s0_addr;
      m_wdata = s0_wdata;
      case (grant)
         2'd1: begin
            cur_req = s1_req;
            m_wr    = s1_wr;
            m_size  = s1_size;
            m_addr  = s1_addr;
            m_wdata = s1_wdata;
         end
         2'd2: begin
            cur_req = s2_req;
            m_wr    = s2_wr;
            m_size  = s2_size;
            m_addr  = s2_addr;
            m_wdata = s2_wdata;
         end
         default: ;
      endcase
   end

   // Route the master handshakes back to the granted requester only.
   // addr_ok deliberately ignores sN_req so the only path is grant/m_addr_ok.
   always_comb begin
      logic a;
      logic d;
      a     = 1'b0;
      d     = 1'b0;
      aok_v = 3'b000;
      dok_v = 3'b000;
      if (state == ADDR) begin
         a = m_addr_ok;
         d = m_addr_ok & m_data_ok;
      end else if (state == DATA) begin
         d = m_data_ok;
      end
      case (grant)
         2'd1:    begin aok_v[1] = a; dok_v[1] = d; end
         2'd2:    begin aok_v[2] = a; dok_v[2] = d; end
         default: begin aok_v[0] = a; dok_v[0] = d; end
      endcase
   end

   assign m_req      = (state == ADDR) & cur_req;
   assign busy       = (state != IDLE);
   assign {s2_addr_ok, s1_addr_ok, s0_addr_ok} = aok_v;
   assign {s2_data_ok, s1_data_ok, s0_data_ok} = dok_v;

   // Read data is broadcast; it is held at zero while reset is asserted.
   assign s0_rdata = aresetn ? m_rdata : '0;
   assign s1_rdata = aresetn ? m_rdata : '0;
   assign s2_rdata = aresetn ? m_rdata : '0;

   // A data_ok is stray unless it completes the transaction in flight.
   assign stray = m_data_ok & ((state == IDLE) | ((state == ADDR) & ~m_addr_ok));

   // Arbitration FSM: grant in IDLE, address phase, then wait for data.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state <= IDLE;
         grant <= 2'd0;
         last  <= 2'd2;
      end else begin
         case (state)
            IDLE: begin
               if (|req_v) begin
                  grant <= winner;
                  state <= ADDR;
               end
            end
            ADDR: begin
               if (m_addr_ok && m_data_ok) begin
                  last  <= grant;
                  state <= IDLE;
               end else if (m_addr_ok) begin
                  state <= DATA;
               end else if (!cur_req) begin
                  state <= IDLE;
               end
            end
            DATA: begin
               if (m_data_ok) begin
                  last  <= grant;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Sticky stray-completion flag, cleared only by reset.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         err_stray <= 1'b0;
      end else if (stray) begin
         err_stray <= 1'b1;
      end
   end

endmodule
`default_nettype wire
